// File: rtl/b4_serial_pkg.sv
// b4_serial_pkg: shared constants and state type for the 4-bit serial link
package b4_serial_pkg;
  localparam int WIDTH_DEF = 4;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  typedef enum logic [1:0] {IDLE, DATA, STOP} rx_state_t;
endpackage

// File: rtl/b4_rx_shift.sv
// b4_rx_shift: LSB-first shift register with bit counter and last-bit flag
module b4_rx_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             clr,
  input  logic             sin,
  output logic [WIDTH-1:0] data,
  output logic             last_bit
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    sr_d = shift ? {sin, sr_q[WIDTH-1:1]} : sr_q;
    cnt_d = clr ? '0 : shift ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
      cnt_q <= '0;
    end else begin
      sr_q <= sr_d;
      cnt_q <= cnt_d;
    end
  end
  assign data = sr_q;
  assign last_bit = cnt_q == CW'(WIDTH - 1);
endmodule

// File: rtl/b4_sipo_rx.sv
// b4_sipo_rx: framed serial receiver with valid/ready output and sticky error flags
module b4_sipo_rx
  import b4_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sin,
  input  logic             q_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] Q_out,
  output logic             q_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);
  rx_state_t state_q, state_d;
  logic [WIDTH-1:0] q_out_q, q_out_d, sr_data;
  logic q_valid_q, q_valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic shift, clr, last_bit;
  b4_rx_shift #(.WIDTH(WIDTH)) u_shift (
    .clk(clk), .rst(rst), .shift(shift), .clr(clr), .sin(sin),
    .data(sr_data), .last_bit(last_bit)
  );
  always_comb begin
    state_d = state_q;
    q_out_d = q_out_q;
    q_valid_d = q_valid_q & ~q_ready;
    frame_err_d = frame_err_q & ~clr_err;
    overrun_d = overrun_q & ~clr_err;
    shift = en && state_q == DATA;
    clr = en && state_q == IDLE && sin == START_BIT;
    if (en)
      case (state_q)
        IDLE: state_d = sin == START_BIT ? DATA : IDLE;
        DATA: state_d = last_bit ? STOP : DATA;
        default: begin
          state_d = IDLE;
          if (sin != STOP_BIT) frame_err_d = 1'b1;
          else if (q_valid_q && !q_ready) overrun_d = 1'b1;
          else begin
            q_out_d = sr_data;
            q_valid_d = 1'b1;
          end
        end
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_out_q <= '0;
      q_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_out_q <= q_out_d;
      q_valid_q <= q_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q <= overrun_d;
    end
  end
  assign Q_out = q_out_q;
  assign q_valid = q_valid_q;
  assign busy = state_q != IDLE;
  assign frame_err = frame_err_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_b4_sipo_rx.sv
// tb_b4_sipo_rx: directed frames with hand-computed expectations for b4_sipo_rx
module tb_b4_sipo_rx;
  import b4_serial_pkg::*;
  logic clk = 1'b0, rst, en, sin, q_ready, clr_err;
  logic [3:0] q_out;
  logic q_valid, busy, frame_err, overrun;
  int checks = 0, errors = 0;
  b4_sipo_rx #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .sin(sin), .q_ready(q_ready), .clr_err(clr_err),
    .Q_out(q_out), .q_valid(q_valid), .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic e, input logic s);
    en = e;
    sin = s;
    @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [3:0] w, input logic stop, input int gap, input logic ce, input logic rdy);
    logic [5:0] bits;
    bits = {stop, w, START_BIT};
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        clr_err = ce;
        q_ready = rdy;
      end
      step(1'b1, bits[i]);
      clr_err = 1'b0;
      q_ready = 1'b0;
      if (i < 5) for (int g = 0; g < gap; g++) step(1'b0, ~bits[i]);
      if (i == 0) chk("busy_start", busy, 1);
    end
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; sin = LINE_IDLE; q_ready = 1'b0; clr_err = 1'b0;
    step(1'b0, LINE_IDLE);
    step(1'b0, LINE_IDLE);
    rst = 1'b0;
    chk("rst_q", q_out, 0);
    chk("rst_valid", q_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    step(1'b1, LINE_IDLE);
    chk("idle_stays", busy, 0);
    // test 1: word 9, en high, latency 6 clocks
    step(1'b1, 0);
    chk("t1_busy1", busy, 1);
    step(1'b1, 1); step(1'b1, 0); step(1'b1, 0); step(1'b1, 1);
    chk("t1_valid5", q_valid, 0);
    chk("t1_busy5", busy, 1);
    step(1'b1, 1);
    chk("t1_q", q_out, 9);
    chk("t1_valid", q_valid, 1);
    chk("t1_busy", busy, 0);
    chk("t1_ferr", frame_err, 0);
    q_ready = 1'b1;
    step(1'b0, LINE_IDLE);
    q_ready = 1'b0;
    chk("t1_consume", q_valid, 0);
    // test 2: strobe every 3rd clock, line toggled on non-strobe edges
    send_frame(4'd15, 1'b1, 2, 1'b0, 1'b0);
    chk("t2_q", q_out, 15);
    chk("t2_valid", q_valid, 1);
    q_ready = 1'b1;
    step(1'b0, LINE_IDLE);
    q_ready = 1'b0;
    chk("t2_ready", q_valid, 0);
    chk("t2_q_hold", q_out, 15);
    step(1'b0, 0);
    chk("t2_no_strobe", busy, 0);
    // test 3: overrun
    send_frame(4'd9, 1'b1, 0, 1'b0, 1'b0);
    chk("t3_q1", q_out, 9);
    send_frame(4'd15, 1'b1, 0, 1'b0, 1'b0);
    chk("t3_ovr", overrun, 1);
    chk("t3_q_keep", q_out, 9);
    chk("t3_valid", q_valid, 1);
    clr_err = 1'b1;
    step(1'b0, LINE_IDLE);
    clr_err = 1'b0;
    chk("t3_clr", overrun, 0);
    q_ready = 1'b1;
    step(1'b0, LINE_IDLE);
    q_ready = 1'b0;
    // test 4: framing error, then good frame
    send_frame(4'd6, 1'b0, 0, 1'b0, 1'b0);
    chk("t4_ferr", frame_err, 1);
    chk("t4_valid", q_valid, 0);
    chk("t4_idle", busy, 0);
    chk("t4_q_keep", q_out, 9);
    send_frame(4'd3, 1'b1, 0, 1'b0, 1'b0);
    chk("t4_q", q_out, 3);
    chk("t4_ferr_sticky", frame_err, 1);
    // test 5: reset mid-frame
    step(1'b1, 0); step(1'b1, 0); step(1'b1, 1);
    rst = 1'b1;
    step(1'b1, 1);
    rst = 1'b0;
    chk("t5_q", q_out, 0);
    chk("t5_valid", q_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ferr", frame_err, 0);
    send_frame(4'd10, 1'b1, 0, 1'b0, 1'b0);
    chk("t5_q10", q_out, 10);
    chk("t5_valid10", q_valid, 1);
    chk("t5_ferr10", frame_err, 0);
    // clear and error on the same edge: the error wins
    send_frame(4'd1, 1'b0, 0, 1'b1, 1'b0);
    chk("clr_vs_ferr", frame_err, 1);
    chk("clr_vs_ferr_q", q_out, 10);
    // test 6: completion coincides with consume of pending word
    q_ready = 1'b1;
    step(1'b0, LINE_IDLE);
    q_ready = 1'b0;
    send_frame(4'd9, 1'b1, 0, 1'b0, 1'b0);
    chk("t6_q9", q_out, 9);
    send_frame(4'd5, 1'b1, 0, 1'b0, 1'b1);
    chk("t6_q", q_out, 5);
    chk("t6_valid", q_valid, 1);
    chk("t6_ovr", overrun, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
